// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache miss path.
package icache_pkg;

  localparam int READ_WORD_WIDTH = 20;
  localparam int ADDR_WIDTH      = 16;
  localparam int WORDS_PER_LINE  = 4;
  localparam int OFFSET_WIDTH    = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } miss_state_t;

endpackage

// File: rtl/icache_miss_ctrl_if.sv
// Miss-controller bus: fetch-side miss input, memory line request/return,
// data/tag array write ports and the missed-word output.
interface icache_miss_ctrl_if #(
  parameter int READ_WORD_WIDTH = icache_pkg::READ_WORD_WIDTH,
  parameter int ADDR_WIDTH      = icache_pkg::ADDR_WIDTH
) ();

  logic                       i_miss;
  logic [ADDR_WIDTH-1:0]      i_miss_addr;
  logic                       o_miss_state;
  logic                       o_mem_req;
  logic [ADDR_WIDTH-1:0]      o_mem_addr;
  logic                       i_mem_ready;
  logic [READ_WORD_WIDTH-1:0] i_mem_word;
  logic                       i_mem_word_valid;
  logic                       o_fill_we;
  logic [ADDR_WIDTH-1:0]      o_fill_addr;
  logic [READ_WORD_WIDTH-1:0] o_fill_word;
  logic                       o_tag_we;
  logic [ADDR_WIDTH-1:0]      o_tag_addr;
  logic [READ_WORD_WIDTH-1:0] o_missed_word;
  logic                       o_missed_word_valid;

  // Controller side: issues memory requests and drives the array write ports.
  modport master (
    input  i_miss, i_miss_addr, i_mem_ready, i_mem_word, i_mem_word_valid,
    output o_miss_state, o_mem_req, o_mem_addr, o_fill_we, o_fill_addr,
           o_fill_word, o_tag_we, o_tag_addr, o_missed_word, o_missed_word_valid
  );

  // Environment side: fetch unit, memory and the cache arrays.
  modport slave (
    output i_miss, i_miss_addr, i_mem_ready, i_mem_word, i_mem_word_valid,
    input  o_miss_state, o_mem_req, o_mem_addr, o_fill_we, o_fill_addr,
           o_fill_word, o_tag_we, o_tag_addr, o_missed_word, o_missed_word_valid
  );

endinterface

// File: rtl/icache_fill_counter.sv
// Beat counter for a line fill: synchronous clear, count enable and a
// last-beat flag. Wraps to zero naturally after the final beat.
module icache_fill_counter #(
  parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clr,
  input  logic                              i_en,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_count,
  output logic                              o_last
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);

  // Beat count register; clear takes priority over enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_en) begin
      o_count <= o_count + 1'b1;
    end
  end

  assign o_last = (o_count == OFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/icache_miss_ctrl.sv
// Single-outstanding instruction-cache miss sequencer: request the line,
// stream beats into the data array, write the tag on the last beat, then
// present the requested word for one cycle.
module icache_miss_ctrl #(
  parameter int READ_WORD_WIDTH = icache_pkg::READ_WORD_WIDTH,
  parameter int ADDR_WIDTH      = icache_pkg::ADDR_WIDTH,
  parameter int WORDS_PER_LINE  = icache_pkg::WORDS_PER_LINE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  icache_miss_ctrl_if.master bus
);

  import icache_pkg::*;

  localparam int OFF_W = $clog2(WORDS_PER_LINE);

  miss_state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [READ_WORD_WIDTH-1:0] word_q;
  logic [ADDR_WIDTH-1:0]      line_base;
  logic [OFF_W-1:0]           beat_cnt;
  logic                       beat_last;
  logic                       cnt_clr;
  logic                       cnt_en;

  assign line_base = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  icache_fill_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_fill_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (cnt_clr),
    .i_en   (cnt_en),
    .o_count(beat_cnt),
    .o_last (beat_last)
  );

  // Miss FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Miss address capture in IDLE and critical-word capture during the fill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q <= '0;
      word_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.i_miss) begin
        addr_q <= bus.i_miss_addr;
      end
      if (state_q == ST_FILL && bus.i_mem_word_valid &&
          beat_cnt == addr_q[OFF_W-1:0]) begin
        word_q <= bus.i_mem_word;
      end
    end
  end

  // Next-state and output decode; fill and tag writes pass through in the beat cycle.
  always_comb begin
    state_d                 = state_q;
    cnt_clr                 = 1'b0;
    cnt_en                  = 1'b0;
    bus.o_mem_req           = 1'b0;
    bus.o_mem_addr          = '0;
    bus.o_fill_we           = 1'b0;
    bus.o_fill_addr         = '0;
    bus.o_fill_word         = '0;
    bus.o_tag_we            = 1'b0;
    bus.o_tag_addr          = '0;
    bus.o_missed_word_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_miss) state_d = ST_REQ;
      end
      ST_REQ: begin
        bus.o_mem_req  = 1'b1;
        bus.o_mem_addr = line_base;
        if (bus.i_mem_ready) begin
          cnt_clr = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.i_mem_word_valid) begin
          cnt_en          = 1'b1;
          bus.o_fill_we   = 1'b1;
          bus.o_fill_addr = {addr_q[ADDR_WIDTH-1:OFF_W], beat_cnt};
          bus.o_fill_word = bus.i_mem_word;
          if (beat_last) begin
            bus.o_tag_we   = 1'b1;
            bus.o_tag_addr = line_base;
            state_d        = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        bus.o_missed_word_valid = 1'b1;
        state_d                 = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_miss_state  = (state_q != ST_IDLE);
  assign bus.o_missed_word = word_q;

endmodule
